conv1d_requant: RTL
===================

# conv1d_requant

Output stage directly downstream of the conv1d accumulator. Takes each raw 32-bit convolution sum with its output-channel index, then:
- adds the channel bias;
- rescales with a TFLite-style fixed-point multiplier and shift;
- adds the output zero-point and clamps to the activation range.

It emits one int8 result per sum through a 4-stage pipeline with valid/ready flow control. Per-channel quantization parameters come from the CPU-side command decoder through a simple write port.

## Interface
- MAX_CHANNELS, 128, depth of per-channel parameter storage
- CH_W, 7, width of channel index (log2 MAX_CHANNELS)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  accumulator sum available
- in_ready  out  1  stage accepts sum this cycle
- in_acc  in  32  signed conv1d accumulator
- in_channel  in  CH_W  output channel of in_acc
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result this cycle
- out_data  out  8  signed int8 result
- param_we  in  1  parameter write strobe
- param_sel  in  3  0 bias, 1 multiplier, 2 shift, 3 output_offset, 4 act_min, 5 act_max; 6–7 ignored
- param_addr  in  CH_W  channel for sel 0–2
- param_wdata  in  32  signed value; act_min/act_max use [7:0], shift uses [5:0]
- out_count  out  32  number of results consumed since reset

## Operation
- Transfer occurs on `in_valid && in_ready` (input) and `out_valid && out_ready` (output).
- The pipeline advances as a whole: `en = !out_valid || out_ready`.
- `in_ready = en`, combinational.
- **S1 (accept):**
  - Compute `x = in_acc + bias[ch]`, 32-bit wrapping.
  - Latch `mult[ch]` and `shift[ch]`.
  - Split shift into `ls = max(shift, 0)` and `rs = max(-shift, 0)`.
  - Legal shift range is −31..+31.
- **S2:**
  - `y = x << ls`, 32-bit wrapping.
  - `p = y * mult`, signed 64-bit.
  - Flag `sat = (y == INT32_MIN && mult == INT32_MIN)`.
- **S3 (SRDHM):**
  - `nudge = p >= 0 ? 2^30 : 1 − 2^30`.
  - `h = (p + nudge) / 2^31`, truncating toward zero.
  - If `sat`, `h = INT32_MAX`.
- **S4:**
  - Rounding divide by power of two: `mask = 2^rs − 1`, `r = h & mask`, `t = (mask >> 1) + (h < 0)`.
  - `q = (h >>> rs) + (r > t)`.
  - `z = q + output_offset`, 32-bit.
  - Clamp to [act_min, act_max], sign-extended to 32 bits; drive `out_data = z[7:0]`.
- Results leave in acceptance order; no reordering or dropping.
- `out_count` increments on each output transfer and wraps at 2^32.
- **Parameter writes:**
  - Take effect on the clock edge of `param_we`.
  - S1 reads parameters combinationally before the write. An item accepted in the same cycle as a write to its channel uses the old value.
  - Items already past S1 are unaffected by writes.
- act_min > act_max is not checked; the result is act_max (max then min order: `min(max(z, act_min), act_max)`).

## Timing
- Latency: 4 cycles from input transfer to `out_valid` with no stall. Throughput is 1 result per cycle.
- Capacity is 4 items. With `out_ready` held low, at most 4 are accepted, then `in_ready = 0` until a drain.
- `out_valid` may not drop without a transfer. `out_data` is stable while `out_valid && !out_ready`.
- Simultaneous output transfer and input transfer in the same cycle is allowed (full rate).
- Reset values, set asynchronously:
  - all stage valids 0, so `out_valid = 0`
  - `out_data = 0`
  - `out_count = 0`
  - `output_offset = 0`, `act_min = −128`, `act_max = 127`
  - `in_ready` reads 1 after reset deasserts
- Per-channel bias/mult/shift storage is block RAM style and is not cleared by reset. Software must rewrite it.
- Reset mid-operation discards all in-flight items; none is emitted afterwards.

## Configuration
- `CONV1D_REQUANT_PER_CHANNEL_EN` defined:
  - bias/mult/shift are arrays of MAX_CHANNELS indexed by `in_channel` / `param_addr`.
- Undefined:
  - a single bias/mult/shift register set; `in_channel` and `param_addr` are ignored;
  - these registers reset to 0;
  - all other behaviour is identical.

## Test plan
- **Basic:** ch 3: bias 24, mult 1073741824, shift 0, offset −128; `in_acc = 1000` → `out_data = 127` (h = 512, z = 384 clamped), 4 cycles after accept.
- **Negative with right shift:** ch 0: bias 0, mult 1073741824, shift −1, offset 5; `in_acc = −300` → `out_data = −70` (h = −150, q = −75).
- **Saturation:** bias 0, mult INT32_MIN, shift 0, offset 0; `in_acc = INT32_MIN` → h = INT32_MAX → `out_data = 127`.
- **Backpressure:** hold `out_ready = 0` and offer 6 sums → exactly 4 accepted and `in_ready = 0`. Release → 4 results in order, then remaining 2, `out_count = 6`.
- **Write collision:** write ch 2 bias = 100 in the same cycle as accepting `in_acc = 0` on ch 2 (old bias 0, unit params) → first result uses bias 0, next item uses 100.
- **Reset mid-stream:** assert reset with 3 items in flight → `out_valid` and `out_count` go to 0 immediately and no stale result appears after release.

Source files
------------

// File: rtl/conv1d_requant_if.sv
// Stream and parameter-port bundle for conv1d_requant.
// slave is the requant stage side; master is the accumulator/CPU/consumer side.
interface conv1d_requant_if #(
    parameter int CH_W = 7
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_acc;
    logic [CH_W-1:0] in_channel;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic            param_we;
    logic [2:0]      param_sel;
    logic [CH_W-1:0] param_addr;
    logic [31:0]     param_wdata;
    logic [31:0]     out_count;

    modport slave (
        input  in_valid, in_acc, in_channel, out_ready,
               param_we, param_sel, param_addr, param_wdata,
        output in_ready, out_valid, out_data, out_count
    );

    modport master (
        output in_valid, in_acc, in_channel, out_ready,
               param_we, param_sel, param_addr, param_wdata,
        input  in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/conv1d_requant.sv
// Requantization stage: bias add, fixed-point rescale, zero-point and clamp to int8.
// Define CONV1D_REQUANT_PER_CHANNEL_EN for per-channel bias/mult/shift storage.
module conv1d_requant #(
    parameter int MAX_CHANNELS = 128,
    parameter int CH_W         = 7
) (
    input logic             clk,
    input logic             rst,
    conv1d_requant_if.slave io
);
    // Handshake: a side transfers when valid && ready; the four stages move
    // together whenever the output register is empty or being taken.
    logic en;

    logic v1_q, v2_q, v3_q, v4_q;
    logic v1_d, v2_d, v3_d, v4_d;

    logic [31:0] cur_bias, cur_mult;
    logic [5:0]  cur_shift;

    logic [31:0] offset_q, offset_d;
    logic [7:0]  act_min_q, act_min_d, act_max_q, act_max_d;

    logic [31:0] x1_q, x1_d, mult1_q, mult1_d;
    logic [4:0]  ls1_q, ls1_d;
    logic [5:0]  rs1_q, rs1_d;

    logic [63:0] p2_q, p2_d;
    logic        sat2_q, sat2_d;
    logic [5:0]  rs2_q, rs2_d;

    logic [31:0] h3_q, h3_d;
    logic [5:0]  rs3_q, rs3_d;

    logic [7:0]  out_data_q, out_data_d;
    logic [31:0] out_count_q, out_count_d;

    logic [31:0] y;
    logic [63:0] nudge, sum, h64;
    logic [32:0] mask33;
    logic [31:0] mask, r, t, hs, q, z, amin, amax, zc1, zc2;

    assign en           = !v4_q || io.out_ready;
    assign io.in_ready  = en;
    assign io.out_valid = v4_q;
    assign io.out_data  = out_data_q;
    assign io.out_count = out_count_q;

`ifdef CONV1D_REQUANT_PER_CHANNEL_EN
    logic [31:0] bias_mem  [MAX_CHANNELS];
    logic [31:0] mult_mem  [MAX_CHANNELS];
    logic [5:0]  shift_mem [MAX_CHANNELS];

    // RAM-style storage: no reset, software reloads it after power-up.
    always_ff @(posedge clk) begin
        if (io.param_we) begin
            case (io.param_sel)
                3'd0:    bias_mem[io.param_addr]  <= io.param_wdata;
                3'd1:    mult_mem[io.param_addr]  <= io.param_wdata;
                3'd2:    shift_mem[io.param_addr] <= io.param_wdata[5:0];
                default: ;
            endcase
        end
    end

    assign cur_bias  = bias_mem[io.in_channel];
    assign cur_mult  = mult_mem[io.in_channel];
    assign cur_shift = shift_mem[io.in_channel];
`else
    logic [31:0] bias_q, bias_d, mult_q, mult_d;
    logic [5:0]  shift_q, shift_d;
    logic        unused_chan;

    always_comb begin
        bias_d  = bias_q;
        mult_d  = mult_q;
        shift_d = shift_q;
        if (io.param_we) begin
            case (io.param_sel)
                3'd0:    bias_d  = io.param_wdata;
                3'd1:    mult_d  = io.param_wdata;
                3'd2:    shift_d = io.param_wdata[5:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q  <= '0;
            mult_q  <= '0;
            shift_q <= '0;
        end else begin
            bias_q  <= bias_d;
            mult_q  <= mult_d;
            shift_q <= shift_d;
        end
    end

    assign cur_bias    = bias_q;
    assign cur_mult    = mult_q;
    assign cur_shift   = shift_q;
    assign unused_chan = ^{io.in_channel, io.param_addr};
`endif

    always_comb begin
        offset_d  = offset_q;
        act_min_d = act_min_q;
        act_max_d = act_max_q;
        if (io.param_we) begin
            case (io.param_sel)
                3'd3:    offset_d  = io.param_wdata;
                3'd4:    act_min_d = io.param_wdata[7:0];
                3'd5:    act_max_d = io.param_wdata[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        v4_d = v4_q;
        if (en) begin
            v1_d = io.in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
            v4_d = v3_q;
        end
    end

    // S1: bias add and split the signed shift into left / right amounts.
    always_comb begin
        x1_d    = io.in_acc + cur_bias;
        mult1_d = cur_mult;
        ls1_d   = cur_shift[5] ? 5'd0 : cur_shift[4:0];
        rs1_d   = cur_shift[5] ? (6'd0 - cur_shift) : 6'd0;
    end

    // S2: pre-shift and full signed 64-bit product.
    always_comb begin
        y      = x1_q << ls1_q;
        p2_d   = {{32{y[31]}}, y} * {{32{mult1_q[31]}}, mult1_q};
        sat2_d = (y == 32'h8000_0000) && (mult1_q == 32'h8000_0000);
        rs2_d  = rs1_q;
    end

    // S3: saturating rounding doubling high multiply; divide truncates toward zero.
    always_comb begin
        nudge = p2_q[63] ? 64'hFFFF_FFFF_C000_0001 : 64'h0000_0000_4000_0000;
        sum   = p2_q + nudge;
        h64   = sum[63] ? (sum + 64'h0000_0000_7FFF_FFFF) : sum;
        h3_d  = sat2_q ? 32'h7FFF_FFFF : h64[62:31];
        rs3_d = rs2_q;
    end

    // S4: round-half-away right shift, zero-point, clamp (max first, then min).
    always_comb begin
        mask33     = (33'd1 << rs3_q) - 33'd1;
        mask       = mask33[31:0];
        r          = h3_q & mask;
        t          = (mask >> 1) + {31'd0, h3_q[31]};
        hs         = $unsigned($signed(h3_q) >>> rs3_q);
        q          = hs + {31'd0, (r > t)};
        z          = q + offset_q;
        amin       = {{24{act_min_q[7]}}, act_min_q};
        amax       = {{24{act_max_q[7]}}, act_max_q};
        zc1        = ($signed(z) < $signed(amin)) ? amin : z;
        zc2        = ($signed(zc1) > $signed(amax)) ? amax : zc1;
        out_data_d = zc2[7:0];
    end

    assign out_count_d = out_count_q + {31'd0, (v4_q && io.out_ready)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            v4_q        <= 1'b0;
            offset_q    <= '0;
            act_min_q   <= 8'h80;
            act_max_q   <= 8'h7F;
            x1_q        <= '0;
            mult1_q     <= '0;
            ls1_q       <= '0;
            rs1_q       <= '0;
            p2_q        <= '0;
            sat2_q      <= 1'b0;
            rs2_q       <= '0;
            h3_q        <= '0;
            rs3_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            v4_q        <= v4_d;
            offset_q    <= offset_d;
            act_min_q   <= act_min_d;
            act_max_q   <= act_max_d;
            out_count_q <= out_count_d;
            if (en) begin
                x1_q       <= x1_d;
                mult1_q    <= mult1_d;
                ls1_q      <= ls1_d;
                rs1_q      <= rs1_d;
                p2_q       <= p2_d;
                sat2_q     <= sat2_d;
                rs2_q      <= rs2_d;
                h3_q       <= h3_d;
                rs3_q      <= rs3_d;
                out_data_q <= out_data_d;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{h64[63], h64[30:0], mask33[32], zc2[31:8]};
endmodule
